// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH clocks per add.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             s, c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign s = a_q[0] ^ b_q[0] ^ carry_q;
  assign c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        carry_d = c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = {s, acc_q[WIDTH-1:1]};
        if (cnt_q == CntLast) begin
          // Output regs change only here, so sum/cout hold the old result while shifting.
          sum_d   = {s, acc_q[WIDTH-1:1]};
          cout_d  = c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB during this last shift.
          ovf_d   = carry_q ^ c;
`endif
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8); ovf checks only when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done with a cycle bound; optionally re-pulses start with new operands mid-op.
  task automatic wait_done(input logic [W-1:0] held, input bit repulse, output int n);
    n = 0;
    while (!done && n < 40) begin
      check("busy_during_shift", 32'(busy), 32'd1);
      check("sum_held_during_shift", 32'(sum), 32'(held));
      if (repulse && n == 2) begin
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int n, input logic [W-1:0] es,
                              input logic ec, input logic eo);
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected unknown ovf expectation");
`endif
  endtask

  task automatic full_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] held, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int n;
    start_op(ta, tb, tc);
    wait_done(held, 1'b0, n);
    check_result(tag, n, es, ec, eo);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    full_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);
    full_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
    full_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0);
    full_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'hFF, 8'h80, 1'b0, 1'b1);

    // Start re-pulsed while busy must be ignored and produce no extra done.
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(8'h80, 1'b1, n);
    check_result("ignore_start", n, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      check("no_extra_done", 32'(done), 32'd0);
      check("no_extra_busy", 32'(busy), 32'd0);
    end

    // Back-to-back: start held in the DONE cycle.
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(8'h02, 1'b0, n);
    check_result("b2b_first", n, 8'h96, 1'b0, 1'b1);
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_accepted_done", 32'(done), 32'd0);
    wait_done(8'h96, 1'b0, n);
    check_result("b2b_second", n, 8'h30, 1'b0, 1'b0);

    // Reset asserted at the 4th shift edge aborts the add.
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
    end

    full_add("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
